// File: rtl/lut_cfg_pkg.sv
// Shared types for the LUT configuration bank: FSM state encoding and the
// config-size helper used to size the active/shadow registers.
package lut_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } cfg_state_e;

  // Total truth-table bits held for n_lut LUTs of k inputs each.
  function automatic int total_bits(input int k, input int n_lut);
    return n_lut * (1 << k);
  endfunction

endpackage

// File: rtl/lut_cfg_bank_if.sv
// Serial bitstream port of the LUT configuration bank.
// Optional macro CFG_READBACK_EN adds cfg_rb_bit (old configuration streamed out).
interface lut_cfg_bank_if;

  logic cfg_start;
  logic cfg_abort;
  logic cfg_valid;
  logic cfg_bit;
  logic cfg_ready;
  logic cfg_busy;
  logic cfg_done;
`ifdef CFG_READBACK_EN
  logic cfg_rb_bit;

  modport master (
    output cfg_start, cfg_abort, cfg_valid, cfg_bit,
    input  cfg_ready, cfg_busy, cfg_done, cfg_rb_bit
  );

  modport slave (
    input  cfg_start, cfg_abort, cfg_valid, cfg_bit,
    output cfg_ready, cfg_busy, cfg_done, cfg_rb_bit
  );
`else
  modport master (
    output cfg_start, cfg_abort, cfg_valid, cfg_bit,
    input  cfg_ready, cfg_busy, cfg_done
  );

  modport slave (
    input  cfg_start, cfg_abort, cfg_valid, cfg_bit,
    output cfg_ready, cfg_busy, cfg_done
  );
`endif

endinterface

// File: rtl/lut_mux.sv
// 2^K:1 combinational truth-table select for a single K-input LUT.
module lut_mux #(
  parameter int K = 4
) (
  input  logic [(1<<K)-1:0] tt,
  input  logic [K-1:0]      sel,
  output logic              out
);

  assign out = tt[sel];

endmodule

// File: rtl/lut_cfg_bank.sv
// Configuration bank for N_LUT K-input LUTs: serial load into a shadow register,
// atomic commit to the active register, registered LUT reads. Macro: CFG_READBACK_EN.
module lut_cfg_bank
  import lut_cfg_pkg::*;
#(
  parameter int K     = 4,
  parameter int N_LUT = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  lut_cfg_bank_if.slave        cfg,
  input  logic [N_LUT*K-1:0]   lut_in,
  output logic [N_LUT-1:0]     lut_out
);

  localparam int TT    = 1 << K;
  localparam int TOTAL = total_bits(K, N_LUT);
  localparam int CW    = $clog2(TOTAL);
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  cfg_state_e        state;
  logic [TOTAL-1:0]  active;
  logic [TOTAL-1:0]  shadow;
  logic [CW-1:0]     count;
  logic [N_LUT-1:0]  lut_sel;
  logic              accept;

  // cfg_ready is registered and equals (state == LOAD), so it doubles as the
  // LOAD qualifier for beat acceptance.
  assign accept = cfg.cfg_valid && cfg.cfg_ready;

  // NOTE: active and shadow are plain flops, not a RAM, so clearing them on
  // reset is legal and required: LUTs must read all-zero tables after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      active        <= '0;
      shadow        <= '0;
      count         <= '0;
      cfg.cfg_ready <= 1'b0;
      cfg.cfg_busy  <= 1'b0;
      cfg.cfg_done  <= 1'b0;
`ifdef CFG_READBACK_EN
      cfg.cfg_rb_bit <= 1'b0;
`endif
    end else begin
      cfg.cfg_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg.cfg_start) begin
            state         <= LOAD;
            count         <= '0;
`ifdef CFG_READBACK_EN
            shadow        <= active;
`else
            shadow        <= '0;
`endif
            cfg.cfg_ready <= 1'b1;
            cfg.cfg_busy  <= 1'b1;
          end
        end

        LOAD: begin
          // Abort beats any beat in the same cycle, including the final one.
          if (cfg.cfg_abort) begin
            state         <= IDLE;
            cfg.cfg_ready <= 1'b0;
            cfg.cfg_busy  <= 1'b0;
          end else if (accept) begin
            shadow <= {cfg.cfg_bit, shadow[TOTAL-1:1]};
            count  <= count + 1'b1;
`ifdef CFG_READBACK_EN
            cfg.cfg_rb_bit <= shadow[0];
`endif
            if (count == LAST) begin
              state         <= COMMIT;
              cfg.cfg_ready <= 1'b0;
              cfg.cfg_done  <= 1'b1;
            end
          end
        end

        COMMIT: begin
          active       <= shadow;
          state        <= IDLE;
          cfg.cfg_busy <= 1'b0;
        end

        default: begin
          state         <= IDLE;
          cfg.cfg_ready <= 1'b0;
          cfg.cfg_busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < N_LUT; i++) begin : g_lut
    lut_mux #(.K(K)) u_mux (
      .tt  (active[i*TT +: TT]),
      .sel (lut_in[i*K +: K]),
      .out (lut_sel[i])
    );
  end

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) lut_out <= '0;
    else        lut_out <= lut_sel;
  end

endmodule

// File: tb/tb_lut_cfg_bank.sv
// Scoreboard bench for lut_cfg_bank: random loads/probes against a truth-table model.
module tb_lut_cfg_bank;
  import lut_cfg_pkg::*;

  localparam int K     = 4;
  localparam int N_LUT = 9;
  localparam int TT    = 16;
  localparam int TOTAL = 144;

  typedef struct {
    logic [N_LUT-1:0] lut;
    logic             ready;
    logic             busy;
    int               tag;
  } probe_t;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [N_LUT*K-1:0] lut_in = '0;
  logic [N_LUT-1:0]   lut_out;

  lut_cfg_bank_if cfg ();

  lut_cfg_bank #(.K(K), .N_LUT(N_LUT)) dut (
    .clk     (clk),
    .reset   (reset),
    .cfg     (cfg),
    .lut_in  (lut_in),
    .lut_out (lut_out)
  );

  always #5 clk = ~clk;

  probe_t           exp_q[$];
  int               done_q[$];
`ifdef CFG_READBACK_EN
  logic             rb_q[$];
`endif
  int               n_cmp = 0;
  int               n_bad = 0;
  int               cyc = 0;
  int               ptag = 0;
  logic             rd_issue = 1'b0;
  logic             rd_d = 1'b0;
  logic             beat_d = 1'b0;
  logic [TOTAL-1:0] model_act = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: LUT i returns bit (i*2^K + its input value) of the configuration.
  function automatic logic [N_LUT-1:0] lut_model(input logic [TOTAL-1:0] act,
                                                 input logic [N_LUT*K-1:0] in);
    logic [N_LUT-1:0] r;
    int sel;
    for (int i = 0; i < N_LUT; i++) begin
      sel  = int'((in >> (i * K)) & 36'hF);
      r[i] = act[i * TT + sel];
    end
    return r;
  endfunction

  function automatic logic [N_LUT*K-1:0] rnd_in();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[N_LUT*K-1:0];
  endfunction

  function automatic logic [TOTAL-1:0] rnd_cfg();
    logic [TOTAL-1:0] t;
    for (int i = 0; i < TOTAL; i++) t[i] = 1'($urandom_range(0, 1));
    return t;
  endfunction

  // Monitor side: flags of what the DUT should present after each edge.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rd_d   <= rd_issue;
    beat_d <= reset && cfg.cfg_valid && cfg.cfg_ready && !cfg.cfg_abort;
  end

  always @(negedge clk) begin
    probe_t e;
    if (rd_d) begin
      if (exp_q.size() == 0) check("probe_queue_empty", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        check($sformatf("lut_out#%0d", e.tag), 32'(lut_out), 32'(e.lut));
        check($sformatf("cfg_ready#%0d", e.tag), 32'(cfg.cfg_ready), 32'(e.ready));
        check($sformatf("cfg_busy#%0d", e.tag), 32'(cfg.cfg_busy), 32'(e.busy));
        check($sformatf("cfg_done#%0d", e.tag), 32'(cfg.cfg_done), 32'd0);
      end
    end
    if (cfg.cfg_done === 1'b1) begin
      if (done_q.size() == 0) check("spurious_cfg_done", 32'(cfg.cfg_done), 32'd0);
      else check("cfg_done_cycle", 32'(cyc), 32'(done_q.pop_front()));
    end
`ifdef CFG_READBACK_EN
    if (beat_d) begin
      if (rb_q.size() == 0) check("rb_queue_empty", 32'(rb_q.size()), 32'd1);
      else check("cfg_rb_bit", 32'(cfg.cfg_rb_bit), 32'(rb_q.pop_front()));
    end
`endif
  end

  // Idle probe: random abort/valid are driven too and must be ignored.
  task automatic probe(input logic [N_LUT*K-1:0] in);
    lut_in        = in;
    cfg.cfg_abort = 1'($urandom_range(0, 1));
    cfg.cfg_valid = 1'($urandom_range(0, 1));
    cfg.cfg_bit   = 1'($urandom_range(0, 1));
    exp_q.push_back('{lut: (reset ? lut_model(model_act, in) : '0),
                      ready: 1'b0, busy: 1'b0, tag: ptag++});
    rd_issue = 1'b1;
    @(posedge clk); #1;
    rd_issue      = 1'b0;
    cfg.cfg_abort = 1'b0;
    cfg.cfg_valid = 1'b0;
  endtask

  task automatic rnd_probes(input int n);
    for (int j = 0; j < n; j++) probe(rnd_in());
  endtask

  // mode 0: valid every cycle, 1: valid every other cycle, 2: random gaps.
  task automatic load(input logic [TOTAL-1:0] bits, input int mode,
                      input int abort_at, input int reset_at, input int probe_at);
    int   i;
    int   iter;
    logic v;
    bit   stop;
    i = 0; iter = 0; stop = 0;
    cfg.cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg.cfg_start = 1'b0;
    while (i < TOTAL && !stop) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (iter % 2) == 1;
        default: v = $urandom_range(0, 3) != 0;
      endcase
      cfg.cfg_valid = v;
      cfg.cfg_bit   = v ? bits[i] : 1'($urandom_range(0, 1));
      cfg.cfg_start = $urandom_range(0, 7) == 0;
      if (v && i == abort_at) cfg.cfg_abort = 1'b1;
      if (v && i == reset_at) reset = 1'b0;
`ifdef CFG_READBACK_EN
      if (v && i != abort_at && i != reset_at) rb_q.push_back(model_act[i]);
`endif
      if (iter == probe_at) begin
        lut_in = rnd_in();
        exp_q.push_back('{lut: lut_model(model_act, lut_in), ready: 1'b1,
                          busy: 1'b1, tag: ptag++});
        rd_issue = 1'b1;
      end
      @(posedge clk); #1;
      rd_issue = 1'b0;
      if (!reset) begin
        reset     = 1'b1;
        model_act = '0;
        stop      = 1;
      end else if (cfg.cfg_abort) begin
        stop = 1;
      end else if (v) begin
        i++;
      end
      cfg.cfg_abort = 1'b0;
      iter++;
    end
    cfg.cfg_valid = 1'b0;
    cfg.cfg_start = 1'b0;
    if (!stop) begin
      done_q.push_back(cyc);
      @(posedge clk); #1;
      model_act = bits;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TOTAL-1:0] and_cfg;
    logic [TOTAL-1:0] pat_a;
    cfg.cfg_start = 1'b0;
    cfg.cfg_abort = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_bit   = 1'b0;
    and_cfg       = '0;
    and_cfg[15]   = 1'b1;
    pat_a         = {72{2'b10}};

    // Reset held for two edges with arbitrary lut_in.
    lut_in = rnd_in();
    @(posedge clk); #1;
    probe(rnd_in());
    reset = 1'b1;
    rnd_probes(2);

    // Full load: 4-input AND in LUT0.
    load(and_cfg, 0, -1, -1, 20);
    probe(36'hF);
    probe(36'hE);
    probe(36'hF_FFFF_FFFF);
    rnd_probes(6);

    // Throttled load of the same configuration.
    load(and_cfg, 1, -1, -1, 7);
    probe(36'hF);
    probe(36'h0);
    rnd_probes(4);

    // Random configurations with random gaps.
    for (int n = 0; n < 3; n++) begin
      load(rnd_cfg(), 2, -1, -1, 5);
      rnd_probes(8);
    end

    // Abort at beat 70 of an all-ones load: AND config must survive.
    load(and_cfg, 0, -1, -1, -1);
    load('1, 0, 70, -1, 10);
    probe(36'h0);
    probe(36'hF);
    rnd_probes(4);

    // Abort on the final beat still abandons the load.
    load('1, 2, TOTAL - 1, -1, -1);
    probe(36'hF);
    probe(36'hE);

    // Reset mid-load at beat 100 clears active.
    load(rnd_cfg(), 0, -1, 100, 30);
    probe(36'hF);
    rnd_probes(4);

    // Readback sequence: A, then zeros (streams A out), then random (streams zeros).
    load(pat_a, 0, -1, -1, -1);
    load('0, 2, -1, -1, 12);
    rnd_probes(3);
    load(rnd_cfg(), 1, -1, -1, -1);
    rnd_probes(6);

    repeat (3) @(posedge clk);
    #1;
    check("pending_probes", 32'(exp_q.size()), 32'd0);
    check("pending_done", 32'(done_q.size()), 32'd0);
`ifdef CFG_READBACK_EN
    check("pending_rb", 32'(rb_q.size()), 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
